seq_multdiv_unit: RTL

Parametrised iterative multiply/divide unit for the pipelined core's execute stage. It replaces the fixed 32-bit multdiv path and adds three capabilities: configurable operand width, a per-operation signed/unsigned mode, and a second result word (high product half or remainder). The execute stage pulses a start strobe and holds the pipeline while `busy` is high. It then consumes `result`, `result_hi` and `data_exception` when `result_ready` pulses.

---
 rtl/seq_multdiv_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_multdiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// over operand magnitudes, with a sign fix-up/exception cycle before completion.
module seq_multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             data_exception,
  output logic             result_ready,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_mul_q, sgn_q, neg_lo_q, neg_hi_q, dz_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             exc_q;

  logic             start, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum, trial, diff;
  logic [WIDTH-1:0] mcand, nxt_hi_d, nxt_lo_d;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo, rem, fix_lo_d, fix_hi_d;
  logic             fix_exc_d;

  assign start    = ctrl_mult | ctrl_div;
  assign a_neg    = signed_mode & operand_a[WIDTH-1];
  assign b_neg    = signed_mode & operand_b[WIDTH-1];
  assign a_mag    = a_neg ? -operand_a : operand_a;
  assign b_mag    = b_neg ? -operand_b : operand_b;
  assign div_zero = ~ctrl_mult & ctrl_div & (operand_b == {WIDTH{1'b0}});

  // One iteration: acc_lo holds the multiplier (mul) or the dividend/quotient (div)
  always_comb begin
    mcand = acc_lo_q[0] ? opb_q : {WIDTH{1'b0}};
    msum  = {1'b0, acc_hi_q} + {1'b0, mcand};
    trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff  = trial - {1'b0, opb_q};
    if (is_mul_q) begin
      nxt_hi_d = msum[WIDTH:1];
      nxt_lo_d = {msum[0], acc_lo_q[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      nxt_hi_d = trial[WIDTH-1:0];
      nxt_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
    end else begin
      nxt_hi_d = diff[WIDTH-1:0];
      nxt_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prod   = {acc_hi_q, acc_lo_q};
    prod_s = neg_lo_q ? -prod : prod;
    quo    = neg_lo_q ? -acc_lo_q : acc_lo_q;
    rem    = neg_hi_q ? -acc_hi_q : acc_hi_q;
    if (dz_q) begin
      fix_lo_d  = {WIDTH{1'b0}};
      fix_hi_d  = {WIDTH{1'b0}};
      fix_exc_d = 1'b1;
    end else if (is_mul_q) begin
      fix_lo_d  = prod_s[WIDTH-1:0];
      fix_hi_d  = prod_s[2*WIDTH-1:WIDTH];
      fix_exc_d = sgn_q ? (fix_hi_d != {WIDTH{fix_lo_d[WIDTH-1]}})
                        : (fix_hi_d != {WIDTH{1'b0}});
    end else begin
      fix_lo_d  = quo;
      fix_hi_d  = rem;
      // Only MIN / -1 yields a non-negated quotient magnitude with the top bit set
      fix_exc_d = sgn_q & ~neg_lo_q & acc_lo_q[WIDTH-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      sgn_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            is_mul_q <= ctrl_mult;
            sgn_q    <= signed_mode;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            dz_q     <= div_zero;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag;
            opb_q    <= b_mag;
            state_q  <= div_zero ? FIX : RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_hi_q <= nxt_hi_d;
          acc_lo_q <= nxt_lo_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          res_q    <= fix_lo_d;
          res_hi_q <= fix_hi_d;
          exc_q    <= fix_exc_d;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result         = res_q;
  assign result_hi      = res_hi_q;
  assign data_exception = exc_q;
  assign result_ready   = (state_q == DONE);
  assign busy           = (state_q == RUN) || (state_q == FIX);
endmodule
